// File: rtl/hls_ch_sequencer_pkg.sv
// Shared definitions for the channel transfer sequencer.
//   ch_seq_state_t : sequencer FSM state encoding
//   CH_CNT_W       : beat counter width, matching the wrapper's channel-length width
package hls_ch_sequencer_pkg;

  localparam int CH_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_CH = 3'd1,
    ST_REQ     = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } ch_seq_state_t;

endpackage

// File: rtl/hls_beat_counter.sv
// Per-channel beat gate and counter.
//   clk_i      : clock
//   clr_i      : synchronous clear of length and count
//   load_i     : latch len_i and zero the count (job start)
//   len_i      : channel beat count to latch
//   run_i      : transfer phase active; ready is forced low otherwise
//   ready_i    : downstream ready to be gated
//   valid_i    : upstream beat valid
//   ready_o    : gated ready, low once the latched length is reached
//   cnt_o      : live beat count
//   len_zero_o : latched length is zero (channel needs no request)
//   complete_o : count reaches the latched length with this cycle's beat
module hls_beat_counter
  import hls_ch_sequencer_pkg::*;
#(
  parameter int CNT_W = CH_CNT_W
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W:0]   len_i,
  input  logic             run_i,
  input  logic             ready_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [CNT_W:0]   cnt_o,
  output logic             len_zero_o,
  output logic             complete_o
);

  logic [CNT_W:0] len_q;
  logic [CNT_W:0] cnt_q;
  logic [CNT_W:0] cnt_nxt;
  logic           beat;

  // Gating at the latched length is what makes the counter saturate.
  assign ready_o    = run_i && (cnt_q < len_q) && ready_i;
  assign beat       = valid_i & ready_o;
  assign cnt_nxt    = cnt_q + {{CNT_W{1'b0}}, beat};
  // Looking at the next count lets the FSM leave RUN the cycle after the last beat.
  assign complete_o = (cnt_nxt == len_q);
  assign len_zero_o = (len_q == '0);
  assign cnt_o      = cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      len_q <= len_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/hls_ch_sequencer.sv
// Channel transfer sequencer: waits for channel-ready flags, issues source and
// sink stream requests, gates/counts beats between streamer and engine, and
// pulses done when both channels have moved their latched lengths.
//   clk_i, rst_i, clear_i        : clock, sync active-high reset, soft clear
//   start_i                      : one-cycle job start (honoured in IDLE only)
//   in_len_i, out_len_i          : channel beat counts
//   ch_in_rdy_i, ch_out_rdy_i    : channel ready levels
//   src_req_o/src_ack_i          : source request handshake
//   sink_req_o/sink_ack_i        : sink request handshake
//   src_valid_i, eng_in_ready_i  : input beat valid / engine ready
//   eng_in_ready_o               : gated ready to streamer source
//   eng_out_valid_i, sink_ready_i: output beat valid / sink ready
//   sink_ready_o                 : gated ready to engine output
//   busy_o, done_o               : status
//   in_cnt_o, out_cnt_o          : live beat counters
module hls_ch_sequencer
  import hls_ch_sequencer_pkg::*;
#(
  parameter int CNT_W = CH_CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           start_i,
  input  logic [CNT_W:0] in_len_i,
  input  logic [CNT_W:0] out_len_i,
  input  logic           ch_in_rdy_i,
  input  logic           ch_out_rdy_i,
  output logic           src_req_o,
  input  logic           src_ack_i,
  output logic           sink_req_o,
  input  logic           sink_ack_i,
  input  logic           src_valid_i,
  input  logic           eng_in_ready_i,
  output logic           eng_in_ready_o,
  input  logic           eng_out_valid_i,
  input  logic           sink_ready_i,
  output logic           sink_ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [CNT_W:0] in_cnt_o,
  output logic [CNT_W:0] out_cnt_o
);

  ch_seq_state_t state_q, state_d;
  logic          clr;
  logic          load;
  logic          run;
  logic          src_acked_q, sink_acked_q;
  logic          in_zero, out_zero;
  logic          in_complete, out_complete;
  logic          src_ok, sink_ok;

  assign clr  = rst_i | clear_i;
  assign load = (state_q == ST_IDLE) && start_i;
  assign run  = (state_q == ST_RUN);

  hls_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk_i      (clk_i),
    .clr_i      (clr),
    .load_i     (load),
    .len_i      (in_len_i),
    .run_i      (run),
    .ready_i    (eng_in_ready_i),
    .valid_i    (src_valid_i),
    .ready_o    (eng_in_ready_o),
    .cnt_o      (in_cnt_o),
    .len_zero_o (in_zero),
    .complete_o (in_complete)
  );

  hls_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk_i      (clk_i),
    .clr_i      (clr),
    .load_i     (load),
    .len_i      (out_len_i),
    .run_i      (run),
    .ready_i    (sink_ready_i),
    .valid_i    (eng_out_valid_i),
    .ready_o    (sink_ready_o),
    .cnt_o      (out_cnt_o),
    .len_zero_o (out_zero),
    .complete_o (out_complete)
  );

  // A zero-length channel never requests and is treated as already acked.
  assign src_req_o  = (state_q == ST_REQ) && !src_acked_q  && !in_zero;
  assign sink_req_o = (state_q == ST_REQ) && !sink_acked_q && !out_zero;
  assign src_ok     = src_acked_q  || in_zero  || src_ack_i;
  assign sink_ok    = sink_acked_q || out_zero || sink_ack_i;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_WAIT_CH;
      ST_WAIT_CH: if (ch_in_rdy_i && ch_out_rdy_i) state_d = ST_REQ;
      ST_REQ:     if (src_ok && sink_ok) state_d = ST_RUN;
      ST_RUN:     if (in_complete && out_complete) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      src_acked_q  <= 1'b0;
      sink_acked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_REQ) begin
        src_acked_q  <= src_acked_q  | src_ack_i;
        sink_acked_q <= sink_acked_q | sink_ack_i;
      end else begin
        src_acked_q  <= 1'b0;
        sink_acked_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hls_ch_sequencer.sv
module tb_hls_ch_sequencer;

  localparam int CNT_W = 16;

  logic           clk = 1'b0;
  logic           rst_i, clear_i, start_i;
  logic [CNT_W:0] in_len_i, out_len_i;
  logic           ch_in_rdy_i, ch_out_rdy_i;
  logic           src_req_o, src_ack_i, sink_req_o, sink_ack_i;
  logic           src_valid_i, eng_in_ready_i, eng_in_ready_o;
  logic           eng_out_valid_i, sink_ready_i, sink_ready_o;
  logic           busy_o, done_o;
  logic [CNT_W:0] in_cnt_o, out_cnt_o;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  hls_ch_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .in_len_i        (in_len_i),
    .out_len_i       (out_len_i),
    .ch_in_rdy_i     (ch_in_rdy_i),
    .ch_out_rdy_i    (ch_out_rdy_i),
    .src_req_o       (src_req_o),
    .src_ack_i       (src_ack_i),
    .sink_req_o      (sink_req_o),
    .sink_ack_i      (sink_ack_i),
    .src_valid_i     (src_valid_i),
    .eng_in_ready_i  (eng_in_ready_i),
    .eng_in_ready_o  (eng_in_ready_o),
    .eng_out_valid_i (eng_out_valid_i),
    .sink_ready_i    (sink_ready_i),
    .sink_ready_o    (sink_ready_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .in_cnt_o        (in_cnt_o),
    .out_cnt_o       (out_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stream(input logic v);
    src_valid_i     = v;
    eng_in_ready_i  = v;
    eng_out_valid_i = v;
    sink_ready_i    = v;
  endtask

  task automatic start_job(input int il, input int ol);
    in_len_i  = 17'(il);
    out_len_i = 17'(ol);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    in_len_i = '0; out_len_i = '0;
    ch_in_rdy_i = 1'b1; ch_out_rdy_i = 1'b1;
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    set_stream(1'b1);
    tick(); tick();

    // reset state (stream inputs high to prove the gating)
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_src_req", 32'(src_req_o), 0);
    chk("rst_sink_req", 32'(sink_req_o), 0);
    chk("rst_in_rdy", 32'(eng_in_ready_o), 0);
    chk("rst_sink_rdy", 32'(sink_ready_o), 0);
    chk("rst_in_cnt", 32'(in_cnt_o), 0);
    chk("rst_out_cnt", 32'(out_cnt_o), 0);
    rst_i = 1'b0;
    tick();

    // basic job: in 4, out 2, acks one cycle after request
    start_job(4, 2);
    chk("b_busy", 32'(busy_o), 1);
    chk("b_wait_noreq", 32'(src_req_o), 0);
    tick();
    chk("b_src_req", 32'(src_req_o), 1);
    chk("b_sink_req", 32'(sink_req_o), 1);
    tick();
    chk("b_src_req_hold", 32'(src_req_o), 1);
    src_ack_i = 1'b1; sink_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    chk("b_src_req_drop", 32'(src_req_o), 0);
    chk("b_sink_req_drop", 32'(sink_req_o), 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("b_in_rdy", 32'(eng_in_ready_o), 1);
      chk("b_sink_rdy", 32'(sink_ready_o), 32'(i < 2));
      chk("b_in_cnt", 32'(in_cnt_o), 32'(i));
      chk("b_done_low", 32'(done_o), 0);
      tick();
    end
    chk("b_done", 32'(done_o), 1);
    chk("b_in_final", 32'(in_cnt_o), 4);
    chk("b_out_final", 32'(out_cnt_o), 2);
    chk("b_in_rdy_done", 32'(eng_in_ready_o), 0);
    tick();
    chk("b_done_pulse", 32'(done_o), 0);
    chk("b_idle", 32'(busy_o), 0);
    chk("b_in_hold", 32'(in_cnt_o), 4);

    // backpressure: in 8 with toggling engine ready, out 10 held off
    eng_out_valid_i = 1'b0;
    start_job(8, 10);
    tick();
    src_ack_i = 1'b1; sink_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    for (int k = 0; k < 15; k++) begin
      eng_in_ready_i = ((k % 2) == 0);
      settle();
      chk("bp_in_rdy", 32'(eng_in_ready_o), 32'((k % 2) == 0));
      tick();
    end
    eng_in_ready_i = 1'b1;
    settle();
    chk("bp_in_cnt", 32'(in_cnt_o), 8);
    chk("bp_in_rdy_sat", 32'(eng_in_ready_o), 0);
    chk("bp_busy", 32'(busy_o), 1);
    eng_out_valid_i = 1'b1;
    n = 0;
    while (!done_o && n < 20) begin
      tick();
      n++;
    end
    chk("bp_out_cycles", 32'(n), 10);
    chk("bp_done", 32'(done_o), 1);
    chk("bp_in_cnt_final", 32'(in_cnt_o), 8);
    chk("bp_out_cnt_final", 32'(out_cnt_o), 10);
    tick();

    // late output-channel flag
    ch_out_rdy_i = 1'b0;
    start_job(1, 1);
    for (int i = 0; i < 10; i++) begin
      chk("lf_no_src_req", 32'(src_req_o), 0);
      chk("lf_no_sink_req", 32'(sink_req_o), 0);
      tick();
    end
    ch_out_rdy_i = 1'b1;
    settle();
    chk("lf_req_not_yet", 32'(src_req_o), 0);
    tick();
    chk("lf_src_req", 32'(src_req_o), 1);
    chk("lf_sink_req", 32'(sink_req_o), 1);
    src_ack_i = 1'b1; sink_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    tick();
    chk("lf_done", 32'(done_o), 1);
    tick();

    // split acks: sink 3 cycles ahead of source
    start_job(2, 2);
    tick();
    sink_ack_i = 1'b1;
    settle();
    chk("sa_sink_req", 32'(sink_req_o), 1);
    tick();
    sink_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("sa_sink_dropped", 32'(sink_req_o), 0);
      chk("sa_src_held", 32'(src_req_o), 1);
      chk("sa_not_run", 32'(eng_in_ready_o), 0);
      tick();
    end
    src_ack_i = 1'b1;
    settle();
    chk("sa_src_req_last", 32'(src_req_o), 1);
    tick();
    src_ack_i = 1'b0;
    settle();
    chk("sa_run", 32'(eng_in_ready_o), 1);
    chk("sa_src_drop", 32'(src_req_o), 0);
    tick(); tick();
    chk("sa_done", 32'(done_o), 1);
    tick();

    // zero-length input channel
    start_job(0, 3);
    chk("z_wait_src", 32'(src_req_o), 0);
    tick();
    chk("z_no_src_req", 32'(src_req_o), 0);
    chk("z_sink_req", 32'(sink_req_o), 1);
    sink_ack_i = 1'b1;
    tick();
    sink_ack_i = 1'b0;
    settle();
    chk("z_in_rdy_gated", 32'(eng_in_ready_o), 0);
    chk("z_sink_rdy", 32'(sink_ready_o), 1);
    tick(); tick();
    chk("z_done_early", 32'(done_o), 0);
    tick();
    chk("z_done", 32'(done_o), 1);
    chk("z_out_cnt", 32'(out_cnt_o), 3);
    chk("z_in_cnt", 32'(in_cnt_o), 0);
    tick();

    // both lengths zero: done 4 cycles after start
    start_job(0, 0);
    tick();
    chk("zz_no_src", 32'(src_req_o), 0);
    chk("zz_no_sink", 32'(sink_req_o), 0);
    tick();
    chk("zz_done_early", 32'(done_o), 0);
    tick();
    chk("zz_done", 32'(done_o), 1);
    tick();

    // mid-run clear, then a normal job
    start_job(5, 5);
    tick();
    src_ack_i = 1'b1; sink_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    tick(); tick();
    chk("cl_in_cnt_mid", 32'(in_cnt_o), 2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("cl_idle", 32'(busy_o), 0);
    chk("cl_in_cnt", 32'(in_cnt_o), 0);
    chk("cl_out_cnt", 32'(out_cnt_o), 0);
    chk("cl_no_done", 32'(done_o), 0);
    tick();
    chk("cl_no_done2", 32'(done_o), 0);
    start_job(5, 5);
    tick();
    src_ack_i = 1'b1; sink_ack_i = 1'b1;
    tick();
    src_ack_i = 1'b0; sink_ack_i = 1'b0;
    n = 0;
    while (!done_o && n < 20) begin
      tick();
      n++;
    end
    chk("cl2_cycles", 32'(n), 5);
    chk("cl2_done", 32'(done_o), 1);
    chk("cl2_in_cnt", 32'(in_cnt_o), 5);
    chk("cl2_out_cnt", 32'(out_cnt_o), 5);
    tick();
    chk("cl2_idle", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_ch_sequencer.md
# hls_ch_sequencer

Channel transfer sequencer for the HLS accelerator wrapper. It sits directly downstream of the control wrapper and consumes the per-channel lengths and channel-ready flags that the wrapper decodes from the register file. From these it issues one source request and one sink request to the streamer. It then gates and counts the input and output beats between streamer and engine, and reports completion to the main FSM and slave. It runs one job per `start_i` pulse; the input channel is graph_input_0 and the output channel is output0.

## Interface
Parameters:
- `CNT_W`, 16: width of length and beat counters; lengths are `CNT_W+1` bits so a full `2**CNT_W` count is representable.

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  soft clear from slave, synchronous; same effect as reset.
- `start_i`  in  1  one-cycle job start from slave/main FSM.
- `in_len_i`  in  `CNT_W+1`  input channel beat count (already +1-adjusted by wrapper).
- `out_len_i`  in  `CNT_W+1`  output channel beat count.
- `ch_in_rdy_i`  in  1  input channel ready flag (level, from register file).
- `ch_out_rdy_i`  in  1  output channel ready flag (level).
- `src_req_o`  out  1  source stream request to streamer.
- `src_ack_i`  in  1  streamer accepted source request.
- `sink_req_o`  out  1  sink stream request to streamer.
- `sink_ack_i`  in  1  streamer accepted sink request.
- `src_valid_i`  in  1  source stream beat valid from streamer.
- `eng_in_ready_i`  in  1  engine can accept an input beat.
- `eng_in_ready_o`  out  1  gated ready returned to streamer source.
- `eng_out_valid_i`  in  1  engine output beat valid.
- `sink_ready_i`  in  1  streamer sink can accept a beat.
- `sink_ready_o`  out  1  gated ready returned to engine output.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `in_cnt_o`, `out_cnt_o`  out  `CNT_W+1` each  live beat counters, for debug and status.

## Operation
- States: IDLE, WAIT_CH, REQ, RUN, DONE.
- IDLE:
  - On `start_i`, latch `in_len_i` and `out_len_i`, zero both counters, and go to WAIT_CH.
  - `start_i` is ignored in every other state.
- WAIT_CH: stay until `ch_in_rdy_i` and `ch_out_rdy_i` are both high; the flags are sampled each cycle.
- REQ:
  - `src_req_o` and `sink_req_o` assert together.
  - Each request holds until its own ack is seen high; it drops the cycle after the ack.
  - Once both acks have been seen, go to RUN. The acks may arrive in either order or in the same cycle.
  - A channel with a latched length of 0 issues no request and counts as acked.
- RUN:
  - `eng_in_ready_o = eng_in_ready_i` while `in_cnt < in_len`, else 0.
  - `sink_ready_o = sink_ready_i` while `out_cnt < out_len`, else 0.
  - `in_cnt` increments on `src_valid_i & eng_in_ready_o`.
  - `out_cnt` increments on `eng_out_valid_i & sink_ready_o`.
  - Both counters may increment in the same cycle.
  - Go to DONE in the cycle after both counters equal their latched lengths.
- DONE: `done_o` is high for one cycle, then go to IDLE. The counters hold their final values until the next start.
- Counters saturate at the latched length; no wrap-around is possible.
- `clear_i` or `rst_i` in any state forces IDLE next cycle, zeroes counters and latched lengths, and drops all requests. No `done_o` is produced.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Start to requests:
  - `start_i` in cycle t gives WAIT_CH in t+1.
  - With both ready flags high at t+1, requests are asserted from t+2.
- `eng_in_ready_o` and `sink_ready_o` are combinational from their inputs while in RUN; they are 0 outside RUN.
- Job end:
  - The last beat in cycle t gives DONE in t+1, with `done_o` high in t+1.
  - `busy_o` falls in t+2.
- Both lengths 0: the job passes through REQ (no requests issued) to RUN and completes with no beats. `done_o` rises 4 cycles after `start_i`.

## Structure
- A shared package holds the state enum `ch_seq_state_t` and the counter width constant (aligned with the wrapper's channel-length width).
- One natural sub-module, `hls_beat_counter`, instantiated twice. It contains the latched length, the saturating counter, the gated ready and the complete flag.

## Test plan
- Basic job: in_len=4, out_len=2, flags high, acks one cycle after request, continuous valid/ready → 4 input beats, 2 output beats; `done_o` one cycle after the 4th input beat.
- Backpressure: in_len=8, `eng_in_ready_i` toggles every cycle → exactly 8 accepted beats; `eng_in_ready_o`=0 after the 8th even with `src_valid_i` still high.
- Late channel flag: `ch_out_rdy_i` held low 10 cycles after start → no request until the flag rises; requests assert one cycle later.
- Split acks: `sink_ack_i` 3 cycles before `src_ack_i` → `sink_req_o` drops after its ack; RUN is entered only after `src_ack_i`.
- Zero length: in_len=0, out_len=3 → `src_req_o` never asserts; done after 3 output beats.
- Mid-run clear: `clear_i` after 2 of 5 beats → IDLE, counters 0, no `done_o`; the next start with len=5 completes normally.
